// File: rtl/feedback2serial_tx.sv
// feedback2serial_tx: snapshots the three motor feedback words and a status
// byte, then streams the frame FF FA M1h M1l M2h M2l M3h M3l ST CRCh CRCl 00
// through the UART TX byte handshake. CRC-16 (MSB-first) covers M1h..ST.
module feedback2serial_tx #(
  parameter logic [7:0]  HEADER1     = 8'hFF,
  parameter logic [7:0]  HEADER2     = 8'hFA,
  parameter logic [7:0]  TRAILER     = 8'h00,
  parameter logic [15:0] CRC_POLY    = 16'h1021,
  parameter logic [15:0] CRC_INIT    = 16'h0000,
  parameter int unsigned PERIOD_CLKS = 0
) (
  input  logic        iCLK,
  input  logic        iRst_n,
  input  logic        iSend,
  input  logic [15:0] iMotor1_fb,
  input  logic [15:0] iMotor2_fb,
  input  logic [15:0] iMotor3_fb,
  input  logic [7:0]  iStatus,
  input  logic        iTx_ready,
  output logic [7:0]  oTx_data,
  output logic        oTx_start,
  output logic        oBusy,
  output logic        oFrame_done,
  output logic [15:0] oCrc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_GUARD,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'd11;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] m1_q, m1_d;
  logic [15:0] m2_q, m2_d;
  logic [15:0] m3_q, m3_d;
  logic [7:0]  st_q, st_d;
  logic        pending_q, pending_d;
  logic [15:0] crc_out_q, crc_out_d;

  logic        tick;
  logic        req;
  logic        issue;
  logic [7:0]  byte_sel;

  // Fold one byte into the running CRC, MSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[15] ^ b[7 - i]) r = {r[14:0], 1'b0} ^ CRC_POLY;
      else                  r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Free-running auto-send period counter; ticks on wrap.
  if (PERIOD_CLKS > 0) begin : g_tick
    localparam int unsigned CW = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    // Next count and wrap detection.
    always_comb begin
      wrap  = (cnt_q == CW'(PERIOD_CLKS - 1));
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge iCLK or negedge iRst_n) begin
      if (!iRst_n) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign tick = wrap;
  end else begin : g_no_tick
    assign tick = 1'b0;
  end

  // Manual request and periodic tick merge into a single request.
  assign req   = iSend | tick;
  assign issue = (state_q == S_ISSUE) && iTx_ready;

  // Byte selected by the current frame index.
  always_comb begin
    byte_sel = TRAILER;
    case (idx_q)
      4'd0:    byte_sel = HEADER1;
      4'd1:    byte_sel = HEADER2;
      4'd2:    byte_sel = m1_q[15:8];
      4'd3:    byte_sel = m1_q[7:0];
      4'd4:    byte_sel = m2_q[15:8];
      4'd5:    byte_sel = m2_q[7:0];
      4'd6:    byte_sel = m3_q[15:8];
      4'd7:    byte_sel = m3_q[7:0];
      4'd8:    byte_sel = st_q;
      4'd9:    byte_sel = crc_q[15:8];
      4'd10:   byte_sel = crc_q[7:0];
      default: byte_sel = TRAILER;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge iCLK or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      crc_q     <= CRC_INIT;
      m1_q      <= '0;
      m2_q      <= '0;
      m3_q      <= '0;
      st_q      <= '0;
      pending_q <= 1'b0;
      crc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      crc_q     <= crc_d;
      m1_q      <= m1_d;
      m2_q      <= m2_d;
      m3_q      <= m3_d;
      st_q      <= st_d;
      pending_q <= pending_d;
      crc_out_q <= crc_out_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    m1_d      = m1_q;
    m2_d      = m2_q;
    m3_d      = m3_q;
    st_d      = st_q;
    crc_out_d = crc_out_q;

    case (state_q)
      S_IDLE: begin
        if (req || pending_q) state_d = S_LOAD;
      end
      S_LOAD: begin
        m1_d    = iMotor1_fb;
        m2_d    = iMotor2_fb;
        m3_d    = iMotor3_fb;
        st_d    = iStatus;
        crc_d   = CRC_INIT;
        idx_d   = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (iTx_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q >= 4'd2 && idx_q <= 4'd8) crc_d = crc_byte(crc_q, byte_sel);
          state_d = S_GUARD;
        end
      end
      S_GUARD: begin
        // idx already points past the byte just issued, so the trailer has
        // gone out once it exceeds LAST_IDX.
        state_d = (idx_q > LAST_IDX) ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        crc_out_d = crc_q;
        // A queued request starts the next frame straight away.
        state_d   = (req || pending_q) ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // One-deep request queue: set while busy, consumed on entering LOAD.
    pending_d = pending_q;
    if (state_d == S_LOAD)                 pending_d = 1'b0;
    else if (req && (state_q != S_IDLE))   pending_d = 1'b1;
  end

  // Output decode from state.
  always_comb begin
    oTx_start   = issue;
    oTx_data    = issue ? byte_sel : '0;
    oBusy       = (state_q != S_IDLE);
    oFrame_done = (state_q == S_DONE);
    oCrc        = crc_out_q;
  end

endmodule
